// File: rtl/spi_ll_arbiter.sv
// Arbitrates the shared byte-level SPI engine among CMD, TX and RX requesters.
// Whole transactions are granted; a watchdog reclaims the engine from a stalled owner.
module spi_ll_arbiter #(
    parameter int TW = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_req,
    input  logic       i_tx_req,
    input  logic       i_rx_req,
    input  logic       i_cmd_stb,
    input  logic       i_tx_stb,
    input  logic       i_rx_stb,
    input  logic [7:0] i_cmd_byte,
    input  logic [7:0] i_tx_byte,
    input  logic [7:0] i_rx_byte,
    output logic       o_cmd_busy,
    output logic       o_tx_busy,
    output logic       o_rx_busy,
    output logic       o_cmd_stb,
    output logic       o_tx_stb,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_byte_all,
    output logic       o_ll_stb,
    output logic [7:0] o_ll_byte,
    input  logic       i_ll_busy,
    input  logic       i_ll_stb,
    input  logic [7:0] i_ll_byte,
    output logic [2:0] o_grant,
    output logic       o_ll_active,
    output logic       o_timeout
);
    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    grant_reg, grant_next;
    logic [2:0]    mask_reg, mask_next;
    logic [TW-1:0] wd_reg, wd_next, wd_inc;
    logic          timeout_reg, timeout_next;

    logic [2:0] req_vec, stb_vec, eligible, pick;
    logic [2:0] busy_vec, rstb_vec;
    logic [7:0] byte_vec [3];
    logic [7:0] sel_byte [3];
    logic       owned, owner_req, owner_stb, ll_stb, accept, activity;

    assign req_vec     = {i_rx_req, i_tx_req, i_cmd_req};
    assign stb_vec     = {i_rx_stb, i_tx_stb, i_cmd_stb};
    assign byte_vec[0] = i_cmd_byte;
    assign byte_vec[1] = i_tx_byte;
    assign byte_vec[2] = i_rx_byte;

    assign owned     = (state_reg == OWNED);
    assign owner_req = |(grant_reg & req_vec);
    assign owner_stb = |(grant_reg & stb_vec);
    assign ll_stb    = owned && owner_stb && owner_req;
    assign accept    = ll_stb && !i_ll_busy;
    assign activity  = accept || (owned && i_ll_stb);

    // Per-requester byte select, busy and return-strobe routing, all off the registered grant
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            assign sel_byte[gi] = byte_vec[gi] & {8{grant_reg[gi]}};
            assign busy_vec[gi] = !(owned && grant_reg[gi]) || i_ll_busy;
            assign rstb_vec[gi] = i_ll_stb && grant_reg[gi];
        end
    endgenerate

    // Requesters that timed out stay masked until they drop req
    assign eligible = req_vec & ~mask_reg;
    assign pick     = eligible[0] ? 3'b001 :
                      eligible[1] ? 3'b010 :
                      eligible[2] ? 3'b100 : 3'b000;
    assign wd_inc   = (wd_reg == {TW{1'b1}}) ? wd_reg : wd_reg + TW'(1);

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        wd_next      = wd_reg;
        timeout_next = 1'b0;
        mask_next    = mask_reg & req_vec;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    grant_next = pick;
                    wd_next    = '0;
                    state_next = OWNED;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    state_next = DRAIN;
                end else if (activity) begin
                    wd_next = '0;
                end else begin
                    wd_next = wd_inc;
                    if (wd_inc == {TW{1'b1}}) begin
                        timeout_next = 1'b1;
                        mask_next    = mask_next | grant_reg;
                        state_next   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!i_ll_busy && !i_ll_stb) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            mask_reg    <= '0;
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            mask_reg    <= mask_next;
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
        end
    end

    assign o_ll_stb      = ll_stb;
    assign o_ll_byte     = sel_byte[0] | sel_byte[1] | sel_byte[2];
    assign o_cmd_busy    = busy_vec[0];
    assign o_tx_busy     = busy_vec[1];
    assign o_rx_busy     = busy_vec[2];
    assign o_cmd_stb     = rstb_vec[0];
    assign o_tx_stb      = rstb_vec[1];
    assign o_rx_stb      = rstb_vec[2];
    assign o_rx_byte_all = i_ll_byte;
    assign o_grant       = grant_reg;
    assign o_ll_active   = (state_reg != IDLE);
    assign o_timeout     = timeout_reg;
endmodule

// File: doc/spi_ll_arbiter.md
# spi_ll_arbiter

Shares the single low-level SPI byte engine among three requesters: the command engine (CMD), the block-write data path (TX) and the block-read data path (RX). Grants whole transactions, not bytes: a requester holds the engine from grant until it drops its request and the engine drains. It routes returned bytes only to the current owner and forcibly reclaims the engine from a stalled owner. It sits between the three SD-card sequencing blocks and the byte-level SPI shifter.

## Interface
- TW, 16: width of the inactivity watchdog counter; timeout after 2^TW-1 idle owned cycles.
- i_clk  in  1  system clock; one clock; all logic on rising edge.
- i_reset  in  1  reset is synchronous and active-high.
- i_cmd_req, i_tx_req, i_rx_req  in  1 each  requester wants/holds the engine (level).
- i_cmd_stb, i_tx_stb, i_rx_stb  in  1 each  requester presents a byte to send; held until accepted.
- i_cmd_byte, i_tx_byte, i_rx_byte  in  8 each  byte to send.
- o_cmd_busy, o_tx_busy, o_rx_busy  out  1 each  byte not accepted this cycle.
- o_cmd_stb, o_tx_stb, o_rx_stb  out  1 each  received byte valid for that requester.
- o_rx_byte_all  out  8  received byte, common to all requesters (qualify with own o_*_stb).
- o_ll_stb  out  1  byte strobe to engine.
- o_ll_byte  out  8  byte to engine.
- i_ll_busy  in  1  engine cannot accept a byte.
- i_ll_stb  in  1  engine returns a received byte.
- i_ll_byte  in  8  received byte.
- o_grant  out  3  one-hot owner {RX,TX,CMD}; 0 when none.
- o_ll_active  out  1  transaction in progress (drives chip-select logic).
- o_timeout  out  1  one-cycle pulse on watchdog reclaim.

## Operation
- States: IDLE, OWNED, DRAIN. Reset -> IDLE, o_grant=0, o_ll_active=0, o_timeout=0, watchdog=0.
- IDLE: if any req, grant the highest-priority requester, fixed CMD > TX > RX. Set o_grant and o_ll_active, then go to OWNED. Otherwise stay.
- OWNED: o_ll_stb = owner's stb & owner's req; o_ll_byte = owner's byte (mux on registered grant).
  - Owner busy = i_ll_busy. Non-owners' busy = 1. Non-owner strobes are ignored, never forwarded.
  - Owner drops req -> DRAIN.
  - A byte is accepted when o_ll_stb && !i_ll_busy.
- DRAIN: o_ll_stb=0, grant retained so in-flight returned bytes still route to the owner. When !i_ll_busy && !i_ll_stb: o_grant<=0, o_ll_active<=0, go to IDLE.
- Return routing: o_X_stb = i_ll_stb && o_grant[X]. o_rx_byte_all = i_ll_byte, passed through. With no grant, i_ll_stb is dropped.
- Watchdog:
  - Clears on grant and on every owner i_ll_stb or accepted byte.
  - Otherwise increments while OWNED, saturating.
  - At all-ones: pulse o_timeout, go to DRAIN regardless of req.
  - After a timeout, the timed-out requester is masked from arbitration until it drops req for ≥1 cycle.
- Requests appearing during OWNED/DRAIN wait; no preemption, even by CMD.
- Reset mid-transaction: the next cycle is IDLE with all outputs at their reset values. Engine bytes in flight are dropped.

## Timing
- Grant latency: req rising in IDLE -> o_grant set on the next edge. The first byte can be forwarded that same cycle (combinational mux) -> minimum 1 cycle from req to o_ll_stb.
- o_ll_stb/o_ll_byte/o_*_busy are combinational from the registered grant and the inputs: zero added latency on the byte path.
- Returned byte: i_ll_stb -> o_X_stb in the same cycle (combinational).
- Release: req falls at cycle n -> DRAIN at n+1 -> IDLE at the earliest at n+2. Regrant at n+2 -> o_grant=0 for ≥1 cycle between owners, so chip-select always deasserts between transactions.
- Simultaneous reqs in IDLE: priority decides. A losing req held across the DRAIN cycles is granted on the first IDLE cycle.

## Test plan
- Single TX transaction, 4 bytes A5,5A,00,FF, engine busy 2 cycles/byte. Required:
  - o_grant=010 one cycle after i_tx_req.
  - o_ll_byte matches, in order.
  - o_tx_busy mirrors i_ll_busy.
  - o_grant=000 two cycles after req drops.
- CMD and RX request on the same cycle. Required:
  - CMD granted first.
  - RX strobes see o_rx_busy=1 and are never forwarded.
  - RX granted right after CMD's DRAIN completes, with ≥1 cycle of o_ll_active=0 between.
- CMD requests while TX owns. Required:
  - No preemption; the TX byte stream continues uninterrupted.
  - CMD is granted after TX releases.
- Returned-byte routing: RX owner, engine returns 0xFE then releases while i_ll_stb of 0x12 is pending in DRAIN. Required:
  - Both bytes appear only on o_rx_stb.
  - o_cmd_stb=o_tx_stb=0 throughout.
- Watchdog (TW=4): CMD owns and goes silent. Required:
  - After 15 idle cycles, o_timeout pulses once and the grant releases.
  - While CMD's req remains high, TX is granted next.
  - CMD is granted again only after its req drops and rises.
- Reset asserted mid-TX-transfer with i_ll_busy=1. Required: the next cycle has o_grant=0, o_ll_stb=0, o_ll_active=0 and the state is IDLE.
